icetap_mem_reader: RTL and testbench
====================================

// Module: icetap_mem_reader
// PURPOSE
//  Read-side sequencer for the capture memory. On a start pulse it walks N words
//  from a start address, wrapping modulo 2^ADDR_WIDTH, and drives the memory's
//  registered read port (1-cycle latency). It streams the words out on a
//  valid/ready interface through a 2-entry buffer.
//  Sits between the capture memory and the host dump/serialiser path.
// PARAMETERS
//  ADDR_WIDTH  8  memory address width; sequencing wraps at 2^ADDR_WIDTH
//  DATA_WIDTH  8  sample word width
// PORTS
//  clk         in   1             single clock; memory read port runs on this clock
//  reset_      in   1             synchronous reset, active low
//  start       in   1             1-cycle pulse: begin a dump (ignored while busy)
//  start_addr  in   ADDR_WIDTH    first address, sampled with start
//  num_words   in   ADDR_WIDTH+1  word count 0..2^ADDR_WIDTH, sampled with start
//  busy        out  1             dump in progress
//  done        out  1             1-cycle pulse: dump finished
//  rd_ena      out  1             memory read enable
//  rd_addr     out  ADDR_WIDTH    memory read address
//  rd_data     in   DATA_WIDTH    memory read data, valid the cycle after rd_ena
//  out_valid   out  1             out_data valid
//  out_ready   in   1             downstream accepts when high with out_valid
//  out_data    out  DATA_WIDTH    sample word
//  out_last    out  1             marks the final word of the dump
// BEHAVIOUR
//  - Reset (reset_=0 at posedge): state IDLE.
//    - Outputs: busy, done, rd_ena, out_valid and out_last are 0; rd_addr and out_data are 0.
//    - Buffer is emptied, any in-flight read is dropped, and all counters are cleared.
//  - Reset asserted mid-dump aborts immediately. done is not pulsed.
//  - States: IDLE -> RUN on start. RUN -> DONE when the last word is handshaken. DONE -> IDLE after 1 cycle.
//  - Timing (start high in cycle T):
//    - busy=1 from T+1.
//    - rd_ena=1 with rd_addr=start_addr in T+1.
//    - The word is captured into the buffer at the end of T+2; out_valid=1 in T+3.
//  - Issue rule: rd_ena=1 only if issued < num_words and occ + inflight - pop < 2.
//    - occ = buffer entries (0..2); inflight = read issued last cycle; pop = out_valid & out_ready.
//    - Gives 1 word/cycle when out_ready is held high.
//  - rd_addr increments by 1 after each issue and wraps from 2^ADDR_WIDTH-1 to 0.
//  - Buffer: 2-entry FIFO. out_data and out_last are stable while out_valid and !out_ready.
//    - A rd_data word is never lost: the issue rule guarantees space.
//  - out_last=1 on word index num_words-1 only.
//  - done=1 for exactly one cycle (state DONE), the cycle after the last handshake; busy=0 in that cycle.
//  - num_words=0: no rd_ena and no out_valid. done pulses in T+1, busy stays 0.
//  - num_words=2^ADDR_WIDTH: every address is read exactly once, in wrap order.
//  - start while busy or DONE is ignored; start_addr and num_words are only sampled in IDLE.
//  - Counters are ADDR_WIDTH+1 bits wide, so the full-depth count does not overflow.
// CONFIGURATION
//  ICETAP_READER_ABORT_EN defined:
//    - Adds input port abort (1 bit).
//    - abort=1 in RUN: next cycle state IDLE, buffer flushed, in-flight rd_data discarded,
//      out_valid=0, busy=0, no done pulse.
//    - abort in IDLE or DONE: no effect. abort has priority over a same-cycle handshake.
//  Not defined:
//    - No abort port; a dump always runs to completion or until reset.
// TESTING
//  1. Memory preloaded mem[i]=i. start, start_addr=0x10, num_words=4, out_ready=1:
//     - out_data 0x10,0x11,0x12,0x13 in T+3..T+6; out_last on 0x13.
//     - done pulses in T+7.
//  2. start_addr=0xFE, num_words=4: rd_addr 0xFE,0xFF,0x00,0x01; data 0xFE,0xFF,0x00,0x01.
//  3. num_words=256, start_addr=0x80, out_ready toggling 1/0 each cycle:
//     - 256 words, in order, no drops or duplicates; data held stable while stalled.
//     - Never more than 2 words buffered or in flight.
//  4. num_words=0: done in T+1; rd_ena and out_valid stay 0.
//     - A second start while busy (num_words=8) is ignored.
//  5. reset_=0 while 3 words remain: all outputs 0 next cycle, no done.
//     - A new start afterwards runs cleanly.
//  6. With ICETAP_READER_ABORT_EN: abort during stall with 2 words buffered:
//     - out_valid=0 and busy=0 next cycle, no done.
//     - A following dump returns the correct data.

Source files
------------

// File: rtl/icetap_mem_reader.sv
// Capture-memory read sequencer: walks num_words addresses from start_addr (wrapping),
// drives a 1-cycle-latency read port and streams words out through a 2-entry buffer.
// Optional abort input is enabled by defining ICETAP_READER_ABORT_EN.
module icetap_mem_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
`ifdef ICETAP_READER_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  rd_ena,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [CW-1:0]         issued_reg;
  logic [CW-1:0]         num_words_reg;
  logic                  inflight_reg;
  logic                  inflight_last_reg;
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            occ_reg;

  logic [DATA_WIDTH-1:0] buf_data [2];
  logic                  buf_last [2];
  logic                  abort_req;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [2:0]            level;
  logic                  can_issue;

`ifdef ICETAP_READER_ABORT_EN
  assign abort_req = abort && (state_reg == RUN);
`else
  assign abort_req = 1'b0;
`endif

  assign out_valid = (occ_reg != 2'd0);
  assign out_data  = out_valid ? buf_data[rd_ptr_reg] : '0;
  assign out_last  = out_valid & buf_last[rd_ptr_reg];

  // Abort wins over a same-cycle handshake.
  assign pop  = out_valid && out_ready && !abort_req;
  assign push = inflight_reg && !abort_req;

  // Reserve a buffer slot for every word already buffered or still in flight.
  assign level     = {1'b0, occ_reg} + {2'b00, inflight_reg};
  assign can_issue = (level < 3'd2) || ((level == 3'd2) && pop);
  assign issue     = (state_reg == RUN) && (issued_reg < num_words_reg) &&
                     can_issue && !abort_req;

  assign rd_ena  = issue;
  assign rd_addr = addr_reg;

  always_ff @(posedge clk) begin
    if (!reset_) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (num_words == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (abort_req)            state_next = IDLE;
        else if (pop && out_last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      addr_reg          <= '0;
      issued_reg        <= '0;
      num_words_reg     <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      wr_ptr_reg        <= 1'b0;
      rd_ptr_reg        <= 1'b0;
      occ_reg           <= 2'd0;
    end else begin
      if ((state_reg == IDLE) && start) begin
        addr_reg      <= start_addr;
        num_words_reg <= num_words;
        issued_reg    <= '0;
      end else if (issue) begin
        addr_reg   <= addr_reg + 1'b1;
        issued_reg <= issued_reg + ONE;
      end
      inflight_last_reg <= (issued_reg == num_words_reg - ONE);
      if (abort_req) begin
        inflight_reg <= 1'b0;
        wr_ptr_reg   <= 1'b0;
        rd_ptr_reg   <= 1'b0;
        occ_reg      <= 2'd0;
      end else begin
        inflight_reg <= issue;
        if (push) wr_ptr_reg <= ~wr_ptr_reg;
        if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
        occ_reg <= occ_reg + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      logic [DATA_WIDTH-1:0] data_reg;
      logic                  last_reg;
      always_ff @(posedge clk) begin
        if (!reset_) begin
          data_reg <= '0;
          last_reg <= 1'b0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          data_reg <= rd_data;
          last_reg <= inflight_last_reg;
        end
      end
      assign buf_data[gi] = data_reg;
      assign buf_last[gi] = last_reg;
    end
  endgenerate

endmodule

// File: tb/tb_icetap_mem_reader.sv
// Bench for icetap_mem_reader: directed dumps against a mem[i]=i model, with a queue
// scoreboard checked by an independent monitor on the falling clock edge.
module tb_icetap_mem_reader;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   num_words;
  logic          abort_drv;
  logic          busy, done, rd_ena;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;

  always #5 clk = ~clk;

  icetap_mem_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset_     (reset_),
    .start      (start),
    .start_addr (start_addr),
    .num_words  (num_words),
`ifdef ICETAP_READER_ABORT_EN
    .abort      (abort_drv),
`endif
    .busy       (busy),
    .done       (done),
    .rd_ena     (rd_ena),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  logic [DW-1:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = i[DW-1:0];
  always @(posedge clk) if (rd_ena) rd_data <= mem[rd_addr];

  logic [AW-1:0] exp_addr_q [$];
  logic [DW:0]   exp_word_q [$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_count = 0;
  int done_cyc = -1;
  int first_pop_cyc = -1;
  int pop_count = 0;
  int outst = 0;
  bit prev_stall = 0;
  logic [DW:0] prev_word = '0;

  always @(posedge clk) cyc++;

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [AW-1:0] ea;
    logic [DW:0]   ew;
    if (!reset_ || abort_drv) begin
      exp_addr_q.delete();
      exp_word_q.delete();
      prev_stall = 0;
      outst = 0;
    end else begin
      if (prev_stall) begin
        total++;
        if (!out_valid || {out_last, out_data} !== prev_word) begin
          bad++;
          $display("FAIL stall_hold: got valid=%0b last/data=%h, required valid=1 last/data=%h",
                   out_valid, {out_last, out_data}, prev_word);
        end
      end
      total++;
      if (outst > 2) begin
        bad++;
        $display("FAIL outstanding: got %0d words buffered/in flight, required <= 2", outst);
      end
      if (rd_ena) begin
        total++;
        if (exp_addr_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_read: got rd_addr=%h, required no read", rd_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (rd_addr !== ea) begin
            bad++;
            $display("FAIL rd_addr: got %h, required %h", rd_addr, ea);
          end
        end
      end
      if (out_valid && out_ready) begin
        total++;
        pop_count++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        if (exp_word_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: got last/data=%h, required no word", {out_last, out_data});
        end else begin
          ew = exp_word_q.pop_front();
          if ({out_last, out_data} !== ew) begin
            bad++;
            $display("FAIL out_word: got last/data=%h, required %h", {out_last, out_data}, ew);
          end
        end
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
        total++;
        if (busy !== 1'b0 || exp_word_q.size() != 0) begin
          bad++;
          $display("FAIL done_state: got busy=%0b pending=%0d, required busy=0 pending=0",
                   busy, exp_word_q.size());
        end
      end
      outst += int'(rd_ena) - int'(out_valid && out_ready);
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic start_dump(input logic [AW-1:0] a, input int n, input bit accept);
    logic [AW-1:0] ad;
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = a;
    num_words  = n[AW:0];
    if (accept) begin
      start_cyc     = cyc;
      first_pop_cyc = -1;
      done_cyc      = -1;
      for (int i = 0; i < n; i++) begin
        ad = a + i[AW-1:0];
        exp_addr_q.push_back(ad);
        exp_word_q.push_back({(i == n - 1), ad});
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle, input string name);
    int dc0;
    dc0 = done_count;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (toggle) out_ready = ~out_ready;
      @(negedge clk); #1;
      if (done_count != dc0) begin
        total++;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL %s_timeout: got no done, required done within %0d cycles", name, budget);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"},      busy,      0);
    check({name, "_done"},      done,      0);
    check({name, "_rd_ena"},    rd_ena,    0);
    check({name, "_rd_addr"},   rd_addr,   0);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_out_data"},  out_data,  0);
    check({name, "_out_last"},  out_last,  0);
  endtask

  initial begin
    int dc0;
    int pc0;
    reset_ = 1'b0; start = 1'b0; start_addr = '0; num_words = '0;
    out_ready = 1'b1; abort_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_ = 1'b1;
    @(negedge clk); #1;
    check_all_zero("reset");

    // 1: basic 4-word dump, latency and done timing
    start_dump(8'h10, 4, 1);
    wait_done(20, 0, "t1");
    check("t1_first_word_latency", first_pop_cyc - start_cyc, 3);
    check("t1_done_latency", done_cyc - start_cyc, 7);
    check("t1_drained", exp_word_q.size(), 0);

    // 2: address wrap
    start_dump(8'hFE, 4, 1);
    wait_done(20, 0, "t2");
    check("t2_drained", exp_word_q.size(), 0);

    // 3: full depth with out_ready toggling
    pc0 = pop_count;
    start_dump(8'h80, 256, 1);
    wait_done(2000, 1, "t3");
    out_ready = 1'b1;
    check("t3_word_count", pop_count - pc0, 256);
    check("t3_drained", exp_word_q.size(), 0);

    // 4: zero-length dump, then a start while busy is ignored
    dc0 = done_count;
    start_dump(8'h00, 0, 1);
    @(negedge clk); #1;
    check("t4_done_T1", done, 1);
    check("t4_busy_T1", busy, 0);
    repeat (3) @(negedge clk);
    #1 check("t4_done_count", done_count - dc0, 1);
    start_dump(8'h40, 8, 1);
    start_dump(8'h90, 8, 0);
    wait_done(40, 0, "t4b");
    dc0 = done_count;
    repeat (12) @(negedge clk);
    #1 check("t4b_no_extra_done", done_count, dc0);
    check("t4b_drained", exp_word_q.size(), 0);

    // 5: reset with 3 words remaining, then a clean dump
    pc0 = pop_count;
    start_dump(8'h20, 8, 1);
    for (int k = 0; k < 40 && (pop_count - pc0) < 5; k++) begin
      @(negedge clk); #1;
    end
    check("t5_reached_5_words", pop_count - pc0, 5);
    dc0 = done_count;
    @(posedge clk); #1 reset_ = 1'b0;
    @(posedge clk); #1 reset_ = 1'b1;
    @(negedge clk); #1;
    check_all_zero("t5_after_reset");
    repeat (5) @(negedge clk);
    #1 check("t5_no_done", done_count, dc0);
    start_dump(8'h60, 5, 1);
    wait_done(30, 0, "t5b");
    check("t5b_drained", exp_word_q.size(), 0);

`ifdef ICETAP_READER_ABORT_EN
    // 6: abort while stalled with two words buffered
    out_ready = 1'b0;
    start_dump(8'h30, 8, 1);
    repeat (6) @(negedge clk);
    #1 check("t6_valid_before_abort", out_valid, 1);
    dc0 = done_count;
    @(posedge clk); #1 abort_drv = 1'b1;
    @(posedge clk); #1 abort_drv = 1'b0;
    @(negedge clk); #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    repeat (4) @(negedge clk);
    #1 check("t6_no_done", done_count, dc0);
    out_ready = 1'b1;
    start_dump(8'h50, 6, 1);
    wait_done(30, 0, "t6b");
    check("t6b_drained", exp_word_q.size(), 0);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion, required finish within 30000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
